clk_div_sched: RTL and testbench

Programmable clock-divider controller: generates a divided clock `div_clk` and a one-cycle period-start strobe `tick` from `clk`. It replaces free-running fixed dividers with a sequenced resource that can start, stop, run bursts of N periods, and change ratio without glitches. It sits between the control/config logic and any downstream block clocked or enabled by a divided clock.

---
 rtl/clk_div_sched_if.sv | 30 +++
 rtl/clk_div_sched.sv | 113 +++++++++++
 tb/tb_clk_div_sched.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_sched_if.sv
// Control/status bundle for clk_div_sched: ratio config handshake,
// start/stop sequencing and the divided-clock outputs.
interface clk_div_sched_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic             stop;
    logic             div_clk;
    logic             tick;
    logic             busy;
    logic             done;
    logic             err;

    // Controller side: drives requests, observes status.
    modport master (
        output cfg_valid, cfg_div, start, burst_len, stop,
        input  cfg_ready, div_clk, tick, busy, done, err
    );

    // Divider side.
    modport slave (
        input  cfg_valid, cfg_div, start, burst_len, stop,
        output cfg_ready, div_clk, tick, busy, done, err
    );
endinterface

// File: rtl/clk_div_sched.sv
// Programmable clock-divider controller. An internal counter walks each
// period; every output is a register taken from that counter one cycle
// later, so a start sampled at edge T shows its first tick after T+1.
// Ratio changes while running wait in a one-entry shadow and take effect
// only on a period boundary, so no period is ever cut or stretched.
module clk_div_sched #(
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 16
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] shd;
    logic             shd_vld;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] blen;
    logic             end_q;

    logic             acc;
    logic             cfg_ok;
    logic             bnd;
    logic             last;
    logic [CNT_W:0]   pcnt_inc;

    // A config is taken whenever the shadow slot is free.
    assign bus.cfg_ready = ~shd_vld;
    assign acc           = bus.cfg_valid & ~shd_vld;
    assign cfg_ok        = (bus.cfg_div >= DIV_W'(2));
    assign bnd           = (state != IDLE) && (cnt == div - DIV_W'(1));
    assign pcnt_inc      = {1'b0, pcnt} + {{CNT_W{1'b0}}, 1'b1};
    // Sequence ends at this boundary on burst completion, a pending drain,
    // or a stop that lands exactly on the boundary (period already whole).
    assign last = bnd && (((blen != '0) && (pcnt_inc == {1'b0, blen})) ||
                          (state == DRAIN) || bus.stop);

    // Sequencer: state, period counter, active ratio and shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            div     <= DIV_W'(DEFAULT_DIV);
            shd     <= '0;
            shd_vld <= 1'b0;
            pcnt    <= '0;
            blen    <= '0;
            end_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    pcnt <= '0;
                    if (acc && cfg_ok) div <= bus.cfg_div;
                    if (bus.start) begin
                        state <= RUN;
                        blen  <= bus.burst_len;
                    end
                end
                RUN, DRAIN: begin
                    if (bnd) begin
                        cnt  <= '0;
                        pcnt <= (&pcnt) ? pcnt : pcnt_inc[CNT_W-1:0];
                        if (shd_vld) begin
                            div     <= shd;
                            shd_vld <= 1'b0;
                        end
                        if (last) begin
                            state <= IDLE;
                            end_q <= 1'b1;
                            // Nothing applies a shadow in IDLE, so go direct.
                            if (acc && cfg_ok) div <= bus.cfg_div;
                        end else if (acc && cfg_ok) begin
                            shd     <= bus.cfg_div;
                            shd_vld <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                        if (bus.stop && state == RUN) state <= DRAIN;
                        if (acc && cfg_ok) begin
                            shd     <= bus.cfg_div;
                            shd_vld <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered outputs derived from the sequencer one cycle behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.busy    <= 1'b0;
            bus.tick    <= 1'b0;
            bus.div_clk <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.busy    <= (state != IDLE);
            bus.tick    <= (state != IDLE) && (cnt == '0);
            bus.div_clk <= (state != IDLE) && (cnt >= (div >> 1));
            bus.done    <= end_q;
            bus.err     <= acc & ~cfg_ok;
        end
    end
endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: a period-level model predicts every output each
// cycle; directed scenarios add literal timing checks, then random traffic.
module tb_clk_div_sched;
    localparam int DIV_W = 16;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clk_div_sched_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus();

    clk_div_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DEFAULT_DIV(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: position inside the current period, its length, periods left.
    bit m_run, m_drain, m_dpend;
    int m_pos, m_div, m_left;
    int pend[$];

    // Observations of the DUT, used by the literal checks.
    int cyc = 0;
    int tq[$];
    int dq[$];
    int n_busy = 0, n_dhi = 0, n_err = 0;

    always @(posedge clk) begin
        bit e_busy, e_tick, e_dclk, e_done, e_err, e_rdy, acc, fin;
        int cd;
        cyc++;
        if (!rst) begin
            m_run = 0; m_drain = 0; m_dpend = 0; m_pos = 0; m_div = 16; m_left = 0;
            pend.delete();
            e_busy = 0; e_tick = 0; e_dclk = 0; e_done = 0; e_err = 0; e_rdy = 1;
        end else begin
            cd     = int'(bus.cfg_div);
            acc    = bus.cfg_valid && (pend.size() == 0);
            e_busy = m_run;
            e_tick = m_run && (m_pos == 0);
            e_dclk = m_run && (m_pos >= m_div / 2);
            e_done = m_dpend;
            e_err  = acc && (cd < 2);
            m_dpend = 0;
            if (!m_run) begin
                if (acc && cd >= 2) m_div = cd;
                if (bus.start) begin
                    m_run = 1; m_drain = 0; m_pos = 0;
                    m_left = (bus.burst_len == 0) ? -1 : int'(bus.burst_len);
                end
            end else if (m_pos == m_div - 1) begin
                if (m_left > 0) m_left--;
                fin = (m_left == 0) || m_drain || bus.stop;
                if (pend.size() != 0) m_div = pend.pop_front();
                m_pos = 0;
                if (fin) begin
                    m_run = 0;
                    m_dpend = 1;
                    if (acc && cd >= 2) m_div = cd;
                end else if (acc && cd >= 2) begin
                    pend.push_back(cd);
                end
            end else begin
                m_pos++;
                if (bus.stop) m_drain = 1;
                if (acc && cd >= 2) pend.push_back(cd);
            end
            e_rdy = (pend.size() == 0);
        end
        #1;
        chk("busy", bus.busy, e_busy);
        chk("tick", bus.tick, e_tick);
        chk("div_clk", bus.div_clk, e_dclk);
        chk("done", bus.done, e_done);
        chk("err", bus.err, e_err);
        chk("cfg_ready", bus.cfg_ready, e_rdy);
        if (bus.tick === 1'b1) tq.push_back(cyc);
        if (bus.done === 1'b1) dq.push_back(cyc);
        if (bus.busy === 1'b1) n_busy++;
        if (bus.div_clk === 1'b1) n_dhi++;
        if (bus.err === 1'b1) n_err++;
    end

    task automatic idle_inputs();
        bus.cfg_valid = 0; bus.cfg_div = '0; bus.start = 0;
        bus.burst_len = '0; bus.stop = 0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input string nm, input int idx);
        if (tq.size() > idx + 1) chk(nm, tq[idx + 1] - tq[idx], 0);
    endtask

    initial begin
        int t0, d0, b0, h0, e0;
        idle_inputs();
        rst = 0;
        wait_n(3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.cfg_ready, 1);
        rst = 1;
        wait_n(2);

        // Burst of 3 at the default ratio.
        t0 = tq.size(); d0 = dq.size(); b0 = n_busy; h0 = n_dhi;
        bus.start = 1; bus.burst_len = 8'd3;
        wait_n(1);
        idle_inputs();
        wait_n(55);
        chk("s1_ticks", tq.size() - t0, 3);
        chk("s1_dones", dq.size() - d0, 1);
        chk("s1_busy_cycles", n_busy - b0, 48);
        chk("s1_high_cycles", n_dhi - h0, 24);
        if (tq.size() >= t0 + 3) begin
            chk("s1_gap0", tq[t0 + 1] - tq[t0], 16);
            chk("s1_gap1", tq[t0 + 2] - tq[t0 + 1], 16);
            if (dq.size() > d0) chk("s1_done_at", dq[d0] - tq[t0], 48);
        end

        // Ratio 5 with start in the same cycle, continuous, then stop.
        t0 = tq.size(); d0 = dq.size(); h0 = n_dhi;
        bus.cfg_valid = 1; bus.cfg_div = 16'd5; bus.start = 1; bus.burst_len = 8'd0;
        wait_n(1);
        idle_inputs();
        wait_n(20);
        chk("s2_high_4periods", n_dhi - h0, 12);
        if (tq.size() >= t0 + 2) chk("s2_gap", tq[t0 + 1] - tq[t0], 5);
        wait_n(2);
        bus.stop = 1;
        wait_n(1);
        idle_inputs();
        wait_n(10);
        chk("s2_dones", dq.size() - d0, 1);
        chk("s2_idle", bus.busy, 0);

        // Ratio 16 running, 4 offered mid-period, 6 held off behind it.
        bus.cfg_valid = 1; bus.cfg_div = 16'd16;
        wait_n(1);
        idle_inputs();
        t0 = tq.size();
        bus.start = 1;
        wait_n(1);
        idle_inputs();
        wait_n(3);
        bus.cfg_valid = 1; bus.cfg_div = 16'd4;
        wait_n(1);
        bus.cfg_div = 16'd6;
        wait_n(22);
        idle_inputs();
        wait_n(10);
        if (tq.size() >= t0 + 4) begin
            chk("s3_gap16", tq[t0 + 1] - tq[t0], 16);
            chk("s3_gap4", tq[t0 + 2] - tq[t0 + 1], 4);
            chk("s3_gap6", tq[t0 + 3] - tq[t0 + 2], 6);
        end else chk("s3_ticks", tq.size() - t0, 4);

        // Rejected ratios while running at 6.
        e0 = n_err;
        bus.cfg_valid = 1; bus.cfg_div = 16'd1;
        wait_n(1);
        bus.cfg_div = 16'd0;
        wait_n(1);
        idle_inputs();
        t0 = tq.size();
        wait_n(14);
        chk("s4_errs", n_err - e0, 2);
        gap("s4_gap_zero_check_unused", tq.size() + 10);
        if (tq.size() >= t0 + 2) chk("s4_gap", tq[t0 + 1] - tq[t0], 6);
        bus.stop = 1;
        wait_n(1);
        idle_inputs();
        wait_n(10);

        // Burst of 2 at ratio 4, stop on final boundary, start ignored in RUN.
        bus.cfg_valid = 1; bus.cfg_div = 16'd4;
        wait_n(1);
        idle_inputs();
        t0 = tq.size(); d0 = dq.size(); b0 = n_busy;
        bus.start = 1; bus.burst_len = 8'd2;
        wait_n(1);
        idle_inputs();
        wait_n(1);
        bus.start = 1; bus.burst_len = 8'd0;
        wait_n(1);
        idle_inputs();
        wait_n(4);
        bus.stop = 1;
        wait_n(1);
        idle_inputs();
        wait_n(8);
        chk("s5_dones", dq.size() - d0, 1);
        chk("s5_ticks", tq.size() - t0, 2);
        chk("s5_busy_cycles", n_busy - b0, 8);

        // Reset mid-period with a shadow pending, then a fresh burst.
        bus.cfg_valid = 1; bus.cfg_div = 16'd9;
        wait_n(1);
        bus.start = 1; bus.cfg_valid = 0;
        wait_n(1);
        idle_inputs();
        wait_n(4);
        bus.cfg_valid = 1; bus.cfg_div = 16'd3;
        wait_n(1);
        idle_inputs();
        d0 = dq.size();
        #2 rst = 0;
        #1;
        chk("ar_busy", bus.busy, 0);
        chk("ar_tick", bus.tick, 0);
        chk("ar_div_clk", bus.div_clk, 0);
        chk("ar_ready", bus.cfg_ready, 1);
        wait_n(2);
        rst = 1;
        wait_n(1);
        chk("ar_no_done", dq.size() - d0, 0);
        b0 = n_busy;
        bus.start = 1; bus.burst_len = 8'd1;
        wait_n(1);
        idle_inputs();
        wait_n(20);
        chk("ar_busy_cycles", n_busy - b0, 16);
        chk("ar_dones", dq.size() - d0, 1);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bus.start     = ($urandom % 20) == 0;
            bus.burst_len = CNT_W'($urandom % 4);
            bus.stop      = ($urandom % 25) == 0;
            bus.cfg_valid = ($urandom % 8) == 0;
            bus.cfg_div   = DIV_W'($urandom_range(0, 9));
            wait_n(1);
        end
        idle_inputs();
        wait_n(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
